button_event_gen: RTL and testbench

//  Front end for the front-panel push buttons (mode, edit_shift, inc, start_stop, reset).

---
 rtl/button_event_gen_if.sv | 23 ++
 rtl/button_event_gen.sv | 202 ++++++++++++++++++++
 tb/tb_button_event_gen.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/button_event_gen_if.sv
// Button front-end bundle: raw pins in, debounced level and event pulses out.
// master = button consumer / test driver, slave = button_event_gen.
interface button_event_gen_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic [N_BTN-1:0] short_pulse;
    logic [N_BTN-1:0] long_pulse;
    logic [N_BTN-1:0] repeat_pulse;

    modport master (
        output btn_in,
        input  btn_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
    );

    modport slave (
        input  btn_in,
        output btn_level, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/button_event_gen.sv
// Front-panel button front end: per-channel synchroniser, debouncer and
// press/release/short/long classification. Auto-repeat is built only when
// BTN_AUTO_REPEAT_EN is defined; otherwise repeat_pulse is tied low.

// One button channel: synchroniser + debounce counter + hold FSM.
module button_event_chan #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 15_000_000,
    parameter int REPEAT_CYC   = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_long,
    output logic o_repeat
);
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_LONG     = 2'd3;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_state;
    logic [DB_W-1:0]        r_db_cnt;
    logic [HOLD_W-1:0]      r_hold_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    logic                   r_short;
    logic                   r_long;

    logic w_s;
    logic w_target;
    logic w_match;
    logic w_db_done;

    assign w_s       = r_sync[SYNC_STAGES-1];
    // Only IDLE waits for a press; every other state waits for a stable 0
    // (DISARMED: arm after release, HELD/LONG: debounced release).
    assign w_target  = (r_state == ST_IDLE);
    assign w_match   = (w_s == w_target);
    assign w_db_done = w_match && (r_db_cnt == DB_W'(DEBOUNCE_CYC - 1));

    // Shift the raw pin through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!reset) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end

    // Count consecutive samples at the level the FSM is waiting for; any other sample restarts it.
    always_ff @(posedge clk) begin
        if (!reset || !w_match || w_db_done) r_db_cnt <= '0;
        else                                 r_db_cnt <= r_db_cnt + 1'b1;
    end

    // Hold FSM; a release accepted on the same cycle the hold limit is reached wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_DISARMED;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            case (r_state)
                ST_DISARMED: begin
                    if (w_db_done) r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (w_db_done) begin
                        r_level    <= 1'b1;
                        r_press    <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (w_db_done) begin
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                        r_short   <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (r_hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                        r_hold_cnt <= HOLD_W'(HOLD_CYC);
                        r_long     <= 1'b1;
                        r_state    <= ST_LONG;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_LONG: begin
                    // hold count stays saturated at HOLD_CYC here
                    if (w_db_done) begin
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_DISARMED;
            endcase
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYC + 1);

    logic [REP_W-1:0] r_rep_cnt;
    logic             r_repeat;

    // Periodic repeat while in LONG; cleared outside LONG and on the release cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rep_cnt <= '0;
            r_repeat  <= 1'b0;
        end else begin
            r_repeat <= 1'b0;
            if (r_state == ST_LONG && !w_db_done) begin
                if (r_rep_cnt == REP_W'(REPEAT_CYC - 1)) begin
                    r_rep_cnt <= '0;
                    r_repeat  <= 1'b1;
                end else begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end else begin
                r_rep_cnt <= '0;
            end
        end
    end

    assign o_repeat = r_repeat;
`else
    logic w_unused_rep;
    assign w_unused_rep = ^REPEAT_CYC;
    assign o_repeat     = 1'b0;
`endif

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_short   = r_short;
    assign o_long    = r_long;
endmodule

// Top: N_BTN independent channels on the interface bundle.
module button_event_gen #(
    parameter int N_BTN        = 5,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 15_000_000,
    parameter int REPEAT_CYC   = 5_000_000
) (
    input logic               clk,
    input logic               reset,
    button_event_gen_if.slave bus
);
    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;
    logic [N_BTN-1:0] w_short;
    logic [N_BTN-1:0] w_long;
    logic [N_BTN-1:0] w_repeat;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        button_event_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .HOLD_CYC    (HOLD_CYC),
            .REPEAT_CYC  (REPEAT_CYC)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .i_btn    (bus.btn_in[g]),
            .o_level  (w_level[g]),
            .o_press  (w_press[g]),
            .o_release(w_release[g]),
            .o_short  (w_short[g]),
            .o_long   (w_long[g]),
            .o_repeat (w_repeat[g])
        );
    end

    assign bus.btn_level     = w_level;
    assign bus.press_pulse   = w_press;
    assign bus.release_pulse = w_release;
    assign bus.short_pulse   = w_short;
    assign bus.long_pulse    = w_long;
    assign bus.repeat_pulse  = w_repeat;
endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: phase table, hand-timed corner sequences and
// random stimulus, all checked every cycle against a streak/age reference model.
module tb_button_event_gen;
    localparam int N_BTN = 5;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int HOLD  = 20;
    localparam int REP   = 5;
`ifdef BTN_AUTO_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;

    button_event_gen_if #(.N_BTN(N_BTN)) bus ();

    button_event_gen #(
        .N_BTN(N_BTN), .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DEB),
        .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // reference model: level streaks and time since press
    bit [N_BTN-1:0] m_p0, m_p1, m_armed, m_level, m_sval, m_long_fired;
    int             m_streak[N_BTN];
    int             m_age[N_BTN];
    bit [N_BTN-1:0] e_press, e_rel, e_short, e_long, e_rep;

    // observed DUT events
    int n_press[N_BTN], n_rel[N_BTN], n_short[N_BTN], n_long[N_BTN], n_rep[N_BTN];
    int t_press[N_BTN], t_rel[N_BTN], t_short[N_BTN], t_long[N_BTN], t_rep1[N_BTN];

    typedef struct {
        logic             rst;
        logic [N_BTN-1:0] btn;
        int               ncyc;
        int               n_press;
        int               n_rel;
        int               n_short;
        int               n_long;
        logic [N_BTN-1:0] lvl_end;
    } vec_t;
    vec_t tab[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_step(input logic rst, input logic [N_BTN-1:0] btn);
        bit s;
        e_press = '0; e_rel = '0; e_short = '0; e_long = '0; e_rep = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (!rst) begin
                m_armed[i] = 0; m_level[i] = 0; m_sval[i] = 0; m_long_fired[i] = 0;
                m_streak[i] = 0; m_age[i] = 0;
            end else begin
                s = m_p1[i];
                if (m_streak[i] > 0 && s == m_sval[i]) m_streak[i]++;
                else begin m_sval[i] = s; m_streak[i] = 1; end
                if (!m_armed[i]) begin
                    if (!s && m_streak[i] == DEB) m_armed[i] = 1;
                end else if (!m_level[i]) begin
                    if (s && m_streak[i] == DEB) begin
                        m_level[i] = 1; e_press[i] = 1; m_age[i] = 0; m_long_fired[i] = 0;
                    end
                end else begin
                    m_age[i]++;
                    if (!s && m_streak[i] == DEB) begin
                        m_level[i] = 0; e_rel[i] = 1; e_short[i] = !m_long_fired[i];
                    end else if (!m_long_fired[i] && m_age[i] == HOLD) begin
                        e_long[i] = 1; m_long_fired[i] = 1;
                    end else if (REP_ON && m_long_fired[i] && (m_age[i] - HOLD) % REP == 0) begin
                        e_rep[i] = 1;
                    end
                end
            end
        end
        m_p1 = rst ? m_p0 : '0;
        m_p0 = rst ? btn : '0;
    endtask

    task automatic clear_rec();
        for (int i = 0; i < N_BTN; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_short[i] = 0; n_long[i] = 0; n_rep[i] = 0;
            t_press[i] = -1; t_rel[i] = -1; t_short[i] = -1; t_long[i] = -1; t_rep1[i] = -1;
        end
    endtask

    task automatic tick(input logic rst, input logic [N_BTN-1:0] btn);
        reset = rst;
        bus.btn_in = btn;
        @(posedge clk);
        #1;
        cyc++;
        model_step(rst, btn);
        check("outputs", 32'({bus.btn_level, bus.press_pulse, bus.release_pulse,
                              bus.short_pulse, bus.long_pulse, bus.repeat_pulse}),
              32'({m_level, e_press, e_rel, e_short, e_long, e_rep}));
        for (int i = 0; i < N_BTN; i++) begin
            if (bus.press_pulse[i])   begin n_press[i]++; t_press[i] = cyc; end
            if (bus.release_pulse[i]) begin n_rel[i]++;   t_rel[i]   = cyc; end
            if (bus.short_pulse[i])   begin n_short[i]++; t_short[i] = cyc; end
            if (bus.long_pulse[i])    begin n_long[i]++;  t_long[i]  = cyc; end
            if (bus.repeat_pulse[i])  begin
                if (n_rep[i] == 0) t_rep1[i] = cyc;
                n_rep[i]++;
            end
        end
    endtask

    task automatic run(input int n, input logic [N_BTN-1:0] btn);
        for (int k = 0; k < n; k++) tick(1'b1, btn);
    endtask

    initial begin : main
        int t0, t1, sp, sr, ss, sl;
        int left[N_BTN];
        int rst_left;
        logic [N_BTN-1:0] rb;

        //           rst   btn       ncyc press rel short long lvl_end
        tab[0]  = '{1'b0, 5'b00000,  3, 0, 0, 0, 0, 5'b00000};
        tab[1]  = '{1'b1, 5'b00000,  8, 0, 0, 0, 0, 5'b00000};
        tab[2]  = '{1'b1, 5'b00001, 10, 1, 0, 0, 0, 5'b00001};
        tab[3]  = '{1'b1, 5'b00000, 10, 0, 1, 1, 0, 5'b00000};
        tab[4]  = '{1'b1, 5'b00100, 40, 1, 0, 0, 1, 5'b00100};
        tab[5]  = '{1'b1, 5'b00000, 10, 0, 1, 0, 0, 5'b00000};
        tab[6]  = '{1'b1, 5'b11111,  3, 0, 0, 0, 0, 5'b00000};
        tab[7]  = '{1'b1, 5'b00000, 10, 0, 0, 0, 0, 5'b00000};
        tab[8]  = '{1'b1, 5'b11010, 12, 3, 0, 0, 0, 5'b11010};
        tab[9]  = '{1'b1, 5'b01000, 10, 0, 2, 2, 0, 5'b01000};
        tab[10] = '{1'b1, 5'b00000, 30, 0, 1, 0, 1, 5'b00000};
        tab[11] = '{1'b0, 5'b00000,  2, 0, 0, 0, 0, 5'b00000};
        tab[12] = '{1'b1, 5'b00010,  8, 0, 0, 0, 0, 5'b00000};
        tab[13] = '{1'b1, 5'b00000,  8, 0, 0, 0, 0, 5'b00000};
        tab[14] = '{1'b1, 5'b00010,  8, 1, 0, 0, 0, 5'b00010};
        tab[15] = '{1'b1, 5'b00000,  8, 0, 1, 1, 0, 5'b00000};

        bus.btn_in = '0;
        clear_rec();

        for (int v = 0; v < 16; v++) begin
            sp = 0; sr = 0; ss = 0; sl = 0;
            for (int k = 0; k < tab[v].ncyc; k++) begin
                tick(tab[v].rst, tab[v].btn);
                sp += $countones(bus.press_pulse);
                sr += $countones(bus.release_pulse);
                ss += $countones(bus.short_pulse);
                sl += $countones(bus.long_pulse);
            end
            check($sformatf("vec%0d press", v), sp, tab[v].n_press);
            check($sformatf("vec%0d release", v), sr, tab[v].n_rel);
            check($sformatf("vec%0d short", v), ss, tab[v].n_short);
            check($sformatf("vec%0d long", v), sl, tab[v].n_long);
            check($sformatf("vec%0d level", v), 32'(bus.btn_level), 32'(tab[v].lvl_end));
        end

        // clean press/release timing on btn 0
        run(8, '0); clear_rec();
        t0 = cyc; run(10, 5'b00001);
        check("t1 press latency", t_press[0] - t0, 6);
        check("t1 level", 32'(bus.btn_level[0]), 1);
        t1 = cyc; run(10, 5'b00000);
        check("t1 release latency", t_rel[0] - t1, 6);
        check("t1 short with release", t_short[0], t_rel[0]);
        check("t1 no long", n_long[0], 0);

        // bounce 1-0-1-0-1 then stable
        run(8, '0); clear_rec();
        tick(1'b1, 5'b00001); tick(1'b1, 5'b00000); tick(1'b1, 5'b00001); tick(1'b1, 5'b00000);
        t0 = cyc; run(15, 5'b00001);
        check("t2 press count", n_press[0], 1);
        check("t2 press latency", t_press[0] - t0, 6);
        run(10, '0);

        // long hold on btn 2
        clear_rec();
        run(40, 5'b00100);
        check("t3 long count", n_long[2], 1);
        check("t3 long delay", t_long[2] - t_press[2], HOLD);
        run(10, '0);
        check("t3 release", n_rel[2], 1);
        check("t3 no short", n_short[2], 0);

        // button held through reset
        clear_rec();
        tick(1'b0, 5'b00001); tick(1'b0, 5'b00001); tick(1'b0, 5'b00001);
        run(15, 5'b00001);
        check("t4 no press while held", n_press[0], 0);
        run(10, '0);
        t0 = cyc; run(10, 5'b00001);
        check("t4 press after rearm", n_press[0], 1);
        check("t4 press latency", t_press[0] - t0, 6);
        run(10, '0);

        // reset while btn 1 in HELD
        clear_rec();
        run(10, 5'b00010);
        tick(1'b0, 5'b00010);
        check("t5 outputs in reset", 32'({bus.btn_level, bus.press_pulse, bus.release_pulse,
                                         bus.short_pulse, bus.long_pulse, bus.repeat_pulse}), 0);
        tick(1'b0, 5'b00000); tick(1'b0, 5'b00000);
        run(20, '0);
        check("t5 no release", n_rel[1], 0);
        check("t5 no short", n_short[1], 0);
        check("t5 one press", n_press[1], 1);

        // auto-repeat on btn 4
        clear_rec();
        run(26, 5'b10000);
        check("t6 long", n_long[4], 1);
        run(40, 5'b10000);
        check("t6 repeat count", n_rep[4], REP_ON ? 8 : 0);
        check("t6 first repeat", t_rep1[4], REP_ON ? t_long[4] + REP : -1);
        run(10, '0);

        // random stimulus against the model
        for (int i = 0; i < N_BTN; i++) left[i] = $urandom_range(1, 30);
        rb = '0; rst_left = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N_BTN; i++) begin
                left[i]--;
                if (left[i] <= 0) begin
                    rb[i] = ~rb[i];
                    left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 45);
                end
            end
            if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
            tick(rst_left == 0, rb);
            if (rst_left > 0) rst_left--;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
